// File: rtl/vreg_pkg.sv
// vreg_pkg: shared vector-register geometry and types for the write arbiter.
package vreg_pkg;
  parameter int VECTOR_SIZE = 8;
  parameter int ELEM_W = 32;
  parameter int VREG_COUNT = 32;
  parameter int VREG_ADDR_W = 5;
  typedef logic [ELEM_W-1:0] vreg_vec_t [VECTOR_SIZE];
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant,
  output logic [2:0]   idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    idx = '0;
    // Scanning downward lets the smallest offset from ptr win.
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) idx = 3'((int'(ptr) + i) % N);
    grant = (|req) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/vreg_write_arbiter.sv
// vreg_write_arbiter: round-robin arbitration of vector register writes with a registered write port.
// Define VREG_WRITE_ARBITER_STATS_EN to add saturating grant_cnt/drop_cnt counters.
module vreg_write_arbiter
  import vreg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VECTOR_SIZE = vreg_pkg::VECTOR_SIZE,
  parameter int ELEM_W = vreg_pkg::ELEM_W
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef VREG_WRITE_ARBITER_STATS_EN
  output logic [15:0]            grant_cnt [NUM_REQ],
  output logic [15:0]            drop_cnt,
`endif
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [VREG_ADDR_W-1:0] req_addr [NUM_REQ],
  input  logic [ELEM_W-1:0]      req_vec [NUM_REQ][VECTOR_SIZE],
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   we,
  output logic [VREG_ADDR_W-1:0] write_addr,
  output logic [ELEM_W-1:0]      write_vec [VECTOR_SIZE],
  output logic [2:0]             grant_id
);
  logic [2:0] rr_ptr, idx;
  logic [NUM_REQ-1:0] grant;
  logic [VREG_ADDR_W-1:0] sel_addr;
  logic [ELEM_W-1:0] sel_vec [VECTOR_SIZE];
  logic xfer;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx)
  );
  assign req_ready = rst ? '0 : grant;
  assign xfer = |req_ready;
  always_comb begin
    sel_addr = '0;
    sel_vec = '{default: '0};
    for (int k = 0; k < NUM_REQ; k++)
      if (grant[k]) begin
        sel_addr = req_addr[k];
        sel_vec = req_vec[k];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rr_ptr <= '0;
      we <= 1'b0;
      write_addr <= '0;
      write_vec <= '{default: '0};
      grant_id <= '0;
    end else begin
      // Address 0 is accepted and latched but never written.
      we <= xfer && sel_addr != '0;
      if (xfer) begin
        rr_ptr <= (idx == 3'(NUM_REQ-1)) ? 3'd0 : idx + 3'd1;
        write_addr <= sel_addr;
        write_vec <= sel_vec;
        grant_id <= idx;
      end
    end
`ifdef VREG_WRITE_ARBITER_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      grant_cnt <= '{default: '0};
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (req_ready[k] && grant_cnt[k] != 16'hFFFF) grant_cnt[k] <= grant_cnt[k] + 16'd1;
      if (xfer && sel_addr == '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vreg_write_arbiter.sv
// tb_vreg_write_arbiter: directed checks of grant order, latency, address-0 drop and reset.
module tb_vreg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [4:0] req_addr [4];
  logic [31:0] req_vec [4][8];
  logic [3:0] req_ready;
  logic we;
  logic [4:0] write_addr;
  logic [31:0] write_vec [8];
  logic [2:0] grant_id;
`ifdef VREG_WRITE_ARBITER_STATS_EN
  logic [15:0] grant_cnt [4];
  logic [15:0] drop_cnt;
`endif
  int passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;

  vreg_write_arbiter dut (
    .clk(clk),
    .rst(rst),
`ifdef VREG_WRITE_ARBITER_STATS_EN
    .grant_cnt(grant_cnt),
    .drop_cnt(drop_cnt),
`endif
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_vec(req_vec),
    .req_ready(req_ready),
    .we(we),
    .write_addr(write_addr),
    .write_vec(write_vec),
    .grant_id(grant_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [31:0] base);
    for (int i = 0; i < 8; i++) req_vec[k][i] = base + 32'(i);
  endtask

  task automatic out(input string tag, input logic exp_we, input logic [4:0] exp_addr, input logic [2:0] exp_gid);
    chk({tag, "_we"}, 64'(we), 64'(exp_we));
    chk({tag, "_addr"}, 64'(write_addr), 64'(exp_addr));
    chk({tag, "_gid"}, 64'(grant_id), 64'(exp_gid));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      req_addr[k] = 5'd9;
      set_vec(k, 32'h0);
    end
    // Reset with all requesters valid: nothing granted, outputs zero.
    req_valid = 4'b1111;
    tick;
    tick;
    chk("rst_ready", 64'(req_ready), 64'h0);
    out("rst", 1'b0, 5'd0, 3'd0);
    chk("rst_vec0", 64'(write_vec[0]), 64'h0);
    rst = 1'b0;
    // Same-address race from requesters 0 and 3.
    req_valid = 4'b1001;
    req_addr[0] = 5'd7;
    req_addr[3] = 5'd7;
    set_vec(0, 32'hA0);
    set_vec(3, 32'hB0);
    #1 chk("race_ready0", 64'(req_ready), 64'b0001);
    tick;
    out("race0", 1'b1, 5'd7, 3'd0);
    chk("race0_vec", 64'(write_vec[0]), 64'hA0);
    req_valid = 4'b1000;
    #1 chk("race_ready3", 64'(req_ready), 64'b1000);
    tick;
    out("race3", 1'b1, 5'd7, 3'd3);
    chk("race3_vec", 64'(write_vec[0]), 64'hB0);
    // Single request from requester 1.
    req_valid = 4'b0010;
    req_addr[1] = 5'd5;
    set_vec(1, 32'd1);
    #1 chk("single_ready", 64'(req_ready), 64'b0010);
    tick;
    out("single", 1'b1, 5'd5, 3'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("single_vec%0d", i), 64'(write_vec[i]), 64'(i + 1));
    // Idle: outputs hold, we drops.
    req_valid = 4'b0000;
    #1 chk("idle_ready", 64'(req_ready), 64'h0);
    tick;
    out("idle", 1'b0, 5'd5, 3'd1);
    chk("idle_vec7", 64'(write_vec[7]), 64'd8);
    // Address 0 from requester 2: accepted, not written.
    req_valid = 4'b0100;
    req_addr[2] = 5'd0;
    #1 chk("a0_ready", 64'(req_ready), 64'b0100);
    tick;
    out("a0", 1'b0, 5'd0, 3'd2);
`ifdef VREG_WRITE_ARBITER_STATS_EN
    chk("a0_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    req_valid = 4'b1001;
    #1 chk("a0_ptr3", 64'(req_ready), 64'b1000);
    tick;
    out("a0_next", 1'b1, 5'd7, 3'd3);
    // All four valid continuously from reset.
    for (int k = 0; k < 4; k++) req_addr[k] = 5'(10 + k);
    rst = 1'b1;
    req_valid = 4'b1111;
    tick;
    chk("rr_rst_we", 64'(we), 64'h0);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 chk($sformatf("rr_ready%0d", n), 64'(req_ready), 64'(4'b0001 << (n % 4)));
      tick;
      out($sformatf("rr%0d", n), 1'b1, 5'(10 + n % 4), 3'(n % 4));
    end
    // Reset asserted during the third grant of a burst.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(req_ready), 64'h0);
    tick;
    out("mid_rst", 1'b0, 5'd0, 3'd0);
    chk("mid_rst_vec0", 64'(write_vec[0]), 64'h0);
    rst = 1'b0;
    req_valid = 4'b1010;
    #1 chk("post_rst_ready", 64'(req_ready), 64'b0010);
    tick;
    out("post_rst", 1'b1, 5'd11, 3'd1);
`ifdef VREG_WRITE_ARBITER_STATS_EN
    chk("post_rst_gcnt1", 64'(grant_cnt[1]), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_valid = 4'b0001;
    repeat (65540) tick;
    chk("sat_gcnt0", 64'(grant_cnt[0]), 64'hFFFF);
    chk("sat_drop", 64'(drop_cnt), 64'h0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vreg_write_arbiter.md
VREG_WRITE_ARBITER -- requirements
Module: vreg_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the vector register write port (2..8).
REQ-002 Parameter VECTOR_SIZE, default 8, 32-bit elements per vector.
REQ-003 Parameter ELEM_W, default 32, element width in bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_addr  input  NUM_REQ x 5  per-requester destination vector register.
REQ-008 req_vec  input  NUM_REQ x VECTOR_SIZE x ELEM_W  per-requester write data, unpacked.
REQ-009 req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer occurs when valid and ready are both high.
REQ-010 we  output  1  registered write enable to the vector register file.
REQ-011 write_addr  output  5  registered write address.
REQ-012 write_vec  output  VECTOR_SIZE x ELEM_W  registered write data, unpacked.
REQ-013 grant_id  output  3  registered index of the requester driving the current write.

Function
REQ-014 Arbitration shall be round-robin: search starts at rr_ptr, wraps from NUM_REQ-1 to 0, first valid requester wins.
REQ-015 req_ready shall be combinational from req_valid and rr_ptr; at most one bit high; zero when no request is valid.
REQ-016 On a transfer from requester k, rr_ptr shall become (k+1) mod NUM_REQ on the next edge; without a transfer rr_ptr holds.
REQ-017 A transfer in cycle N shall produce we=1, write_addr, write_vec and grant_id=k in cycle N+1 (one-cycle latency); no transfer -> we=0 in N+1.
REQ-018 A request to address 0 shall be accepted (ready high, rr_ptr advances) but shall produce we=0 in N+1; write_addr/write_vec/grant_id still update.
REQ-019 Requesters shall hold valid, addr and data stable until ready; the arbiter shall not require it to produce correct grants.
REQ-020 Back-to-back writes to the same address from different requesters shall both issue, in grant order, on consecutive cycles.
REQ-021 write_vec/write_addr/grant_id shall hold their last value while we=0, except as per REQ-018.

Reset
REQ-022 While rst is high: rr_ptr=0, we=0, write_addr=0, write_vec all 0, grant_id=0, req_ready all 0.
REQ-023 A transfer presented in a cycle with rst high shall be discarded; first grant after release starts search at requester 0.

Configuration
REQ-024 Macro VREG_WRITE_ARBITER_STATS_EN: when defined, add output grant_cnt (NUM_REQ x 16) counting transfers per requester and output drop_cnt (16) counting address-0 transfers, both saturating at 0xFFFF and cleared by rst.
REQ-025 Without VREG_WRITE_ARBITER_STATS_EN, those ports and counters shall not exist; all other behaviour identical.

Structure
REQ-026 Package vreg_pkg shall hold VECTOR_SIZE, ELEM_W, VREG_COUNT=32, VREG_ADDR_W=5 and typedef vreg_vec_t (unpacked VECTOR_SIZE x ELEM_W).
REQ-027 Round-robin selection shall be sub-module rr_arbiter (inputs req, ptr; output one-hot grant, encoded index); the datapath register stage stays in vreg_write_arbiter.

Verification
REQ-028 Single request: req_valid=0b0010, addr=5, vec[i]=i+1 -> ready=0b0010 same cycle; next cycle we=1, write_addr=5, write_vec[i]=i+1, grant_id=1.
REQ-029 All four valid continuously from reset -> grants 0,1,2,3,0 in consecutive cycles; we=1 each cycle after the first.
REQ-030 Address 0: requester 2 valid with addr=0 -> ready high, next cycle we=0, rr_ptr=3; with STATS_EN drop_cnt=1.
REQ-031 Reset mid-burst: rst high during third grant -> outputs zero next cycle, we=0; after release with requesters 1 and 3 valid, grant goes to 1.
REQ-032 Same-address race: requesters 0 and 3 valid, both addr=7, distinct data -> two consecutive writes to 7, requester 0 data first.
REQ-033 STATS_EN saturation: force 65536+ grants to requester 0 -> grant_cnt[0] stays 0xFFFF.
